// File: rtl/button_pkg.sv
// button_pkg: shared FSM state encodings, event codes and helpers for the button decoder
package button_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PRESS    = 2'd1;
    localparam logic [1:0] GAP      = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    typedef enum logic [1:0] {
        EVT_SHORT  = 2'd0,
        EVT_LONG   = 2'd1,
        EVT_DOUBLE = 2'd2
    } evt_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus counter debounce of an active-low push-button
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 160_000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press_e,
    output logic rel_e
);

    logic             sync1;
    logic             sync2;
    logic             btn_s;
    logic             differ;
    logic             hit;
    logic [CNT_W-1:0] db_cnt;

    assign btn_s   = ~sync2;
    assign differ  = btn_s != pressed;
    assign hit     = differ && (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press_e = hit & ~pressed;
    assign rel_e   = hit & pressed;

    // Synchronise the raw pin; flops idle at 1 so a released button reads as not pressed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after it has been stable for the full debounce window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt  <= '0;
            pressed <= 1'b0;
        end else begin
            db_cnt  <= (!differ || hit) ? '0 : db_cnt + 1'b1;
            pressed <= hit ? ~pressed : pressed;
        end
    end

endmodule

// File: rtl/button_decoder.sv
// button_decoder: debounced push-button classifier emitting short/long/double press pulses.
// Define DOUBLE_PRESS_EN to enable double-press detection (GAP state); otherwise a release
// classifies a short press immediately and DOUBLE_PRESS stays 0.
import button_pkg::*;

module button_decoder #(
    parameter int DEBOUNCE_CYCLES   = 160_000,
    parameter int LONG_CYCLES       = 8_000_000,
    parameter int DOUBLE_GAP_CYCLES = 4_000_000,
    parameter int CNT_W             = 24
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_N,
    output logic       PRESSED,
    output logic       SHORT_PRESS,
    output logic       LONG_PRESS,
    output logic       DOUBLE_PRESS,
    output logic [7:0] EVT_CNT
);

    localparam logic [CNT_W-1:0] LONG_M = CNT_W'(LONG_CYCLES - 1);
`ifdef DOUBLE_PRESS_EN
    localparam logic [CNT_W-1:0] GAP_M  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
`endif
    // Phase timer stops at the largest threshold so it can never wrap back onto a match
    localparam logic [CNT_W-1:0] T_SAT  = CNT_W'(max2(LONG_CYCLES, DOUBLE_GAP_CYCLES) - 1);

    logic             press_e;
    logic             rel_e;
    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [CNT_W-1:0] t;
    logic             short_n;
    logic             long_n;
    logic             double_n;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk    (CLK),
        .rst    (RST),
        .btn_n  (BTN_N),
        .pressed(PRESSED),
        .press_e(press_e),
        .rel_e  (rel_e)
    );

    // Classification: long threshold beats release, second press beats gap timeout
    always_comb begin
        state_n  = state;
        short_n  = 1'b0;
        long_n   = 1'b0;
        double_n = 1'b0;
        case (state)
            IDLE: state_n = press_e ? PRESS : IDLE;
            PRESS: begin
                if (t == LONG_M) begin
                    long_n  = 1'b1;
                    state_n = WAIT_REL;
                end else if (rel_e) begin
`ifdef DOUBLE_PRESS_EN
                    state_n = GAP;
`else
                    short_n = 1'b1;
                    state_n = IDLE;
`endif
                end
            end
`ifdef DOUBLE_PRESS_EN
            GAP: begin
                if (press_e) begin
                    double_n = 1'b1;
                    state_n  = WAIT_REL;
                end else if (t == GAP_M) begin
                    short_n = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = rel_e ? IDLE : state;
        endcase
    end

    // State, phase timer (cleared on every state entry), registered pulses and event count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            t            <= '0;
            SHORT_PRESS  <= 1'b0;
            LONG_PRESS   <= 1'b0;
            DOUBLE_PRESS <= 1'b0;
            EVT_CNT      <= 8'd0;
        end else begin
            state        <= state_n;
            t            <= (state_n != state) ? '0 : (t == T_SAT) ? t : t + 1'b1;
            SHORT_PRESS  <= short_n;
            LONG_PRESS   <= long_n;
            DOUBLE_PRESS <= double_n;
            EVT_CNT      <= EVT_CNT + {7'd0, short_n | long_n | double_n};
        end
    end

endmodule

// File: tb/tb_button_decoder.sv
// tb_button_decoder: table-driven and directed checks of press classification, latency, ties, reset and wrap
module tb_button_decoder;

    localparam int DB = 4;
    localparam int LG = 32;
    localparam int GP = 16;
`ifdef DOUBLE_PRESS_EN
    localparam bit DPE = 1'b1;
`else
    localparam bit DPE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       pressed;
    logic       short_p;
    logic       long_p;
    logic       double_p;
    logic [7:0] evt_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_s = 0, n_l = 0, n_d = 0, excl = 0;
    int t_rise = 0, t_fall = 0, t_s = 0, t_l = 0, t_d = 0;
    logic prev_p = 1'b0;

    button_decoder #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_CYCLES      (LG),
        .DOUBLE_GAP_CYCLES(GP),
        .CNT_W            (24)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .BTN_N       (btn_n),
        .PRESSED     (pressed),
        .SHORT_PRESS (short_p),
        .LONG_PRESS  (long_p),
        .DOUBLE_PRESS(double_p),
        .EVT_CNT     (evt_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: event totals, edge timestamps, exclusivity
    always @(negedge clk) begin
        if (short_p) begin n_s <= n_s + 1; t_s <= cyc; end
        if (long_p) begin n_l <= n_l + 1; t_l <= cyc; end
        if (double_p) begin n_d <= n_d + 1; t_d <= cyc; end
        if (int'(short_p) + int'(long_p) + int'(double_p) > 1) excl <= excl + 1;
        if (pressed && !prev_p) t_rise <= cyc;
        if (!pressed && prev_p) t_fall <= cyc;
        prev_p <= pressed;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int n);
        btn_n = 1'b0;
        step(n);
        btn_n = 1'b1;
    endtask

    task automatic do_reset();
        btn_n = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int p1, g, p2;
        int s, l, d;
        int sn, ln, dn;
    } vec_t;

    vec_t vt[10];

    initial begin
        int s0, l0, d0, es, el, ed;
        vt[0] = '{3, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1] = '{10, 0, 0, 1, 0, 0, 1, 0, 0};
        vt[2] = '{60, 0, 0, 0, 1, 0, 0, 1, 0};
        vt[3] = '{8, 6, 8, 0, 0, 1, 2, 0, 0};
        vt[4] = '{31, 0, 0, 1, 0, 0, 1, 0, 0};
        vt[5] = '{32, 0, 0, 0, 1, 0, 0, 1, 0};
        vt[6] = '{8, 16, 8, 0, 0, 1, 2, 0, 0};
        vt[7] = '{8, 17, 8, 2, 0, 0, 2, 0, 0};
        vt[8] = '{4, 0, 0, 1, 0, 0, 1, 0, 0};
        vt[9] = '{8, 6, 3, 1, 0, 0, 1, 0, 0};

        step(1);
        check("rst_pressed", int'(pressed), 0);
        check("rst_pulses", int'(short_p) + int'(long_p) + int'(double_p), 0);
        check("rst_evt", int'(evt_cnt), 0);
        rst = 1'b0;
        step(2);
        check("idle_pressed", int'(pressed), 0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            s0 = n_s; l0 = n_l; d0 = n_d;
            press(vt[i].p1);
            if (vt[i].g > 0) begin
                step(vt[i].g);
                press(vt[i].p2);
            end
            step(60);
            es = DPE ? vt[i].s : vt[i].sn;
            el = DPE ? vt[i].l : vt[i].ln;
            ed = DPE ? vt[i].d : vt[i].dn;
            check($sformatf("vec%0d_short", i), n_s - s0, es);
            check($sformatf("vec%0d_long", i), n_l - l0, el);
            check($sformatf("vec%0d_double", i), n_d - d0, ed);
            check($sformatf("vec%0d_evt", i), int'(evt_cnt), es + el + ed);
        end

        // Short press timing relative to the debounced release
        do_reset();
        press(10);
        step(40);
        check("short_latency", t_s - t_fall, DPE ? GP : 0);

        // Long press timing relative to the debounced press
        do_reset();
        press(60);
        step(20);
        check("long_latency", t_l - t_rise, LG);
        check("long_pressed_after", int'(pressed), 0);

`ifdef DOUBLE_PRESS_EN
        do_reset();
        press(8);
        step(6);
        press(8);
        step(30);
        check("double_latency", t_d - t_rise, 0);
`endif

        // Reset while the classification is open
        do_reset();
        press(10);
        step(10);
        rst = 1'b1;
        #1;
        check("midrst_pressed", int'(pressed), 0);
        check("midrst_evt", int'(evt_cnt), 0);
        check("midrst_pulses", int'(short_p) + int'(long_p) + int'(double_p), 0);
        step(1);
        rst = 1'b0;
        s0 = n_s;
        step(40);
        check("midrst_no_short", n_s - s0, 0);
        check("midrst_evt_after", int'(evt_cnt), 0);

        // Button held through reset release is a fresh press after debounce
        do_reset();
        btn_n = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        #1;
        check("hold_rst_pressed0", int'(pressed), 0);
        step(10);
        check("hold_rst_pressed1", int'(pressed), 1);
        btn_n = 1'b1;
        step(40);

        // 256 events wrap the counter
        do_reset();
        s0 = n_s;
        repeat (256) begin
            press(8);
            step(GP + 12);
        end
        check("wrap_shorts", n_s - s0, 256);
        check("wrap_evt", int'(evt_cnt), 0);

        check("exclusive", excl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
